alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: in_clk input 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have in_reset input 1, synchronous active-high reset.
REQ-003 SHALL have in_valid input 1, instruction offered.
REQ-004 SHALL have in_instr input 17, instruction: [2:0] op, [4:3] rd, [6:5] ra, [8:7] rb, [9] imm_sel, [16:10] reserved-zero... imm carried in separate port.
REQ-005 SHALL have in_imm input 8, immediate operand, sampled with in_instr.
REQ-006 SHALL have out_ready output 1, instruction accepted when in_valid && out_ready.
REQ-007 SHALL have out_alu_a, out_alu_b output 8, registered ALU operands.
REQ-008 SHALL have out_alu_op output 3, registered ALU opcode.
REQ-009 SHALL have in_alu_result input 9, combinational result returned by the ALU.
REQ-010 SHALL have out_result output 9, last captured result; out_carry output 1, out_result[8] of last writeback.
REQ-011 SHALL have out_done output 1, one-cycle pulse per completed instruction.
REQ-012 SHALL have in_rd_addr input 2 / out_rd_data output 8, combinational register read-back.
REQ-013 SHALL have out_err output 1, illegal-opcode pulse (see Configuration).

Function
REQ-014 SHALL hold four 8-bit registers r0..r3.
REQ-015 Opcodes SHALL be NULL=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6; 7 illegal.
REQ-016 FSM states SHALL be IDLE, ISSUE, DONE; out_ready=1 only in IDLE.
REQ-017 IDLE, on accept: out_alu_op<=op; out_alu_a<=(imm_sel&&op==NULL)?in_imm:r[ra]; out_alu_b<=(imm_sel&&op!=NULL)?in_imm:r[rb]; go ISSUE.
REQ-018 ISSUE, next edge: r[rd]<=in_alu_result[7:0], out_result<=in_alu_result, out_carry<=in_alu_result[8]; go DONE.
REQ-019 DONE: out_done=1 for exactly this cycle; next edge go IDLE.
REQ-020 Latency SHALL be accept edge N -> out_done high in cycle N+2; throughput one instruction per 3 cycles.
REQ-021 Write in ISSUE SHALL be visible to any later instruction (no hazard: next accept only in IDLE).
REQ-022 out_alu_* SHALL hold their values outside ISSUE until next accept.
REQ-023 in_valid without out_ready SHALL be ignored; in_instr need not be held.
REQ-024 out_rd_data SHALL reflect r[in_rd_addr] including write on same edge after that edge.

Reset
REQ-025 In reset: r0..r3=0, out_alu_a/b=0, out_alu_op=NULL, out_result=0, out_carry=0, out_done=0, out_err=0, state IDLE, out_ready=0 while in_reset high.
REQ-026 Reset in ISSUE or DONE SHALL abort: no register write, no out_done.

Configuration
REQ-027 Macro ALU_SEQ_ERR_EN: when defined, op=7 accepted in IDLE SHALL skip ISSUE, write nothing, pulse out_err (not out_done) next cycle, return IDLE.
REQ-028 Without ALU_SEQ_ERR_EN, op=7 SHALL execute as NULL; out_err tied 0.

Structure
REQ-029 Shared package alu_seq_pkg SHALL hold opcode constants, FSM state encodings, instruction field positions.
REQ-030 Register file SHALL be sub-module alu_seq_regfile (1 write, 3 read ports: ra, rb, in_rd_addr).

Verification (bench wires alu_sequencer to the team ALU)
REQ-031 NULL imm 0x80->r1; NULL imm 0x80->r2; ADD r3=r1+r2 -> out_result 0x100, out_carry 1, r3 0x00.
REQ-032 Load r0=0x05, r1=0x07; SUB r2=r0-r1 -> r2 0xFE; out_done exactly 2 cycles after accept.
REQ-033 r0=0x0F; NOT r1=r0 -> r1 0xF0; AND imm 0x3C with r1 -> 0x30.
REQ-034 in_valid held high 10 cycles -> exactly 4 accepts (cycles 0,3,6,9), out_ready low in ISSUE/DONE.
REQ-035 in_reset asserted in ISSUE of ADD into r2=0x55 -> r2 0x00, no out_done, out_ready 1 cycle after release.
REQ-036 op=7: with ALU_SEQ_ERR_EN out_err pulse, registers unchanged; without, r[rd]<=r[ra], out_done pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and instruction field layout for alu_sequencer
package alu_seq_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RES_W   = 9;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned INSTR_W = 17;

  localparam int unsigned OP_LSB      = 0;
  localparam int unsigned RD_LSB      = 3;
  localparam int unsigned RA_LSB      = 5;
  localparam int unsigned RB_LSB      = 7;
  localparam int unsigned IMM_SEL_BIT = 9;
  localparam int unsigned RSVD_LSB    = 10;

  typedef enum logic [OP_W-1:0] {
    OP_NULL = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOT  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - four 8-bit registers, one write port, three combinational read ports
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-cycle IDLE/ISSUE/DONE sequencer driving an external ALU
// Optional ALU_SEQ_ERR_EN: opcode 7 raises out_err instead of executing as NULL.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic               in_clk,
  input  logic               in_reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_imm,
  output logic               out_ready,
  output logic [DATA_W-1:0]  out_alu_a,
  output logic [DATA_W-1:0]  out_alu_b,
  output logic [OP_W-1:0]    out_alu_op,
  input  logic [RES_W-1:0]   in_alu_result,
  output logic [RES_W-1:0]   out_result,
  output logic               out_carry,
  output logic               out_done,
  input  logic [ADDR_W-1:0]  in_rd_addr,
  output logic [DATA_W-1:0]  out_rd_data,
  output logic               out_err
);

  op_e               dec_op;
  op_e               exec_op;
  logic              imm_sel;
  logic              illegal;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              unused_reserved;
  state_e            state;

  assign dec_op          = op_e'(in_instr[OP_LSB +: OP_W]);
  assign rd              = in_instr[RD_LSB +: ADDR_W];
  assign ra              = in_instr[RA_LSB +: ADDR_W];
  assign rb              = in_instr[RB_LSB +: ADDR_W];
  assign imm_sel         = in_instr[IMM_SEL_BIT];
  assign unused_reserved = ^in_instr[INSTR_W-1:RSVD_LSB];

`ifdef ALU_SEQ_ERR_EN
  assign exec_op = dec_op;
  assign illegal = (dec_op == OP_ILL);
`else
  assign exec_op = (dec_op == OP_ILL) ? OP_NULL : dec_op;
  assign illegal = 1'b0;
`endif

  alu_seq_regfile u_regfile (
    .clk     (in_clk),
    .reset   (in_reset),
    .we      (state == ST_ISSUE),
    .waddr   (wr_addr),
    .wdata   (in_alu_result[DATA_W-1:0]),
    .ra_addr (ra),
    .rb_addr (rb),
    .rd_addr (in_rd_addr),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rd_data (out_rd_data)
  );

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state      <= ST_IDLE;
      out_ready  <= 1'b0;
      out_alu_a  <= '0;
      out_alu_b  <= '0;
      out_alu_op <= OP_NULL;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_done   <= 1'b0;
      out_err    <= 1'b0;
      wr_addr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_done  <= 1'b0;
          out_err   <= 1'b0;
          out_ready <= 1'b1;
          if (in_valid && out_ready) begin
            out_ready <= 1'b0;
            if (illegal) begin
              // Illegal op reuses DONE as its single pulse cycle, touching nothing else.
              out_err <= 1'b1;
              state   <= ST_DONE;
            end else begin
              out_alu_op <= exec_op;
              out_alu_a  <= (imm_sel && exec_op == OP_NULL) ? in_imm : ra_data;
              out_alu_b  <= (imm_sel && exec_op != OP_NULL) ? in_imm : rb_data;
              wr_addr    <= rd;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          out_result <= in_alu_result;
          out_carry  <= in_alu_result[RES_W-1];
          out_done   <= 1'b1;
          state      <= ST_DONE;
        end
        default: begin
          out_done  <= 1'b0;
          out_err   <= 1'b0;
          out_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
